branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage direct-mapped BTB plus 2-bit PHT.
- Produces pre_is_branch_taken / pre_branch_addr, which travel with the instruction to the execute-stage branch unit.
- Trained by the branch unit's resolved outcome: update_en, taken_or_not_actual, branch_actual_addr, pc_dispatch.
- Not-taken prediction address is pc+8, matching the branch unit's not-taken actual address, so a correct not-taken prediction causes no flush.

Parameters:
INDEX_W  6   BTB/PHT index width; 2**INDEX_W entries each
TAG_W    10  BTB tag width
GHR_W    6   global history length; used only with the optional feature; must be <= INDEX_W

Ports:
clk                  in   1   clock
rst                  in   1   synchronous active-high reset
stall                in   1   fetch stall; hold prediction outputs
fetch_valid          in   1   fetch_pc valid this cycle
fetch_pc             in   32  fetch address to predict
branch_flush         in   1   execute redirect; kill in-flight prediction
pred_valid           out  1   prediction outputs valid
pred_pc              out  32  pc the prediction belongs to
pre_is_branch_taken  out  1   predicted taken
pre_branch_addr      out  32  predicted next pc
update_en            in   1   resolved branch training strobe
pc_dispatch          in   32  pc of resolved branch
taken_or_not_actual  in   1   resolved direction
branch_actual_addr   in   32  resolved target (pc+8 when not taken)

Behaviour:
- Field extraction from any pc:
  - idx = pc[INDEX_W+1:2]
  - tag = pc[INDEX_W+TAG_W+1:INDEX_W+2]
- Storage:
  - BTB entry = {valid, tag, target[31:0]}.
  - PHT entry = 2-bit saturating counter.
- Reset (rst=1 at a clk edge):
  - all BTB valid bits cleared; all PHT counters set to 2'b01.
  - pred_valid, pre_is_branch_taken = 0; pred_pc, pre_branch_addr = 0; GHR = 0.
  - Reset overrides simultaneous fetch and update.
- Lookup, 1-cycle latency. On an edge with stall=0 and branch_flush=0:
  - pred_valid <= fetch_valid
  - pred_pc <= fetch_pc
  - hit = valid[idx] && tag match
  - pre_is_branch_taken <= hit && pht[idx][1]
  - pre_branch_addr <= taken ? btb_target : fetch_pc+8
  - When fetch_valid=0: pred_valid <= 0; other outputs may hold.
- Stall: with stall=1 and branch_flush=0, all outputs hold their values and fetch_pc is ignored.
- Flush: branch_flush=1 forces pred_valid <= 0 next edge, regardless of stall or fetch_valid. The fetch in the same cycle is dropped.
- Update on an edge with update_en=1, using u = idx(pc_dispatch):
  - PHT: pht[u] increments when taken (saturating at 11), otherwise decrements (saturating at 00).
  - BTB, taken: valid[u] <= 1, tag <= tag(pc_dispatch), target <= branch_actual_addr. This allocates or replaces the entry.
  - BTB, not taken: entry unchanged, including on a miss.
- Updates are never blocked by stall or branch_flush. There is at most one update per cycle.
- Same-cycle lookup and update to the same index: lookup uses pre-update contents (read-before-write); no bypass.
- Address arithmetic is 32-bit and wraps: 0xFFFFFFF8 + 8 = 0x00000000.
- Storage is implemented in flops, so reset clears valid bits in one cycle. No multi-cycle init FSM.

Optional Feature:
- Macro: BRANCH_GHR_EN.
- Defined:
  - GHR_W-bit register GHR; on each update_en, GHR <= {GHR[GHR_W-2:0], taken_or_not_actual}.
  - GHR is non-speculative: it changes only on update_en and is not restored on flush.
  - PHT lookup index = idx(fetch_pc) XOR zero-extended GHR; PHT update index = idx(pc_dispatch) XOR GHR value before the update.
  - BTB indexing is unchanged.
- Undefined:
  - No GHR register exists.
  - PHT uses plain idx for both lookup and update, exactly as in Behaviour.

Test Plan:
1. Reset, then fetch 0x1C000000 -> next cycle pred_valid=1, pre_is_branch_taken=0, pre_branch_addr=0x1C000008.
2. update_en, pc_dispatch=0x1C000010, taken=1, target=0x1C000100; then fetch 0x1C000010 -> taken=1 (counter 01->10), addr=0x1C000100.
3. Same pc, two not-taken updates -> counter 10->01->00; fetch gives taken=0, addr=0x1C000018. A third not-taken update keeps the counter at 00.
4. Alias fetch 0x1C000110 (same idx, different tag) after test 2 -> miss: taken=0, addr=0x1C000118.
5. stall=1 for 3 cycles with changing fetch_pc -> outputs constant. Then branch_flush=1 with stall=1 -> pred_valid=0 next cycle. An update in the same cycle still trains the PHT.
6. Fetch and taken update to the same idx in one cycle -> prediction reflects old state. The next fetch of that pc reflects the new state.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped BTB + 2-bit PHT with 1-cycle registered prediction, trained by resolved branches.
// Optional global-history XOR indexing of the PHT is enabled with `define BRANCH_GHR_EN.
module branch_predictor #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10,
  parameter int GHR_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        branch_flush,
  output logic        pred_valid,
  output logic [31:0] pred_pc,
  output logic        pre_is_branch_taken,
  output logic [31:0] pre_branch_addr,
  input  logic        update_en,
  input  logic [31:0] pc_dispatch,
  input  logic        taken_or_not_actual,
  input  logic [31:0] branch_actual_addr
);

  localparam int N = 1 << INDEX_W;

  logic [N-1:0]       btb_valid_q;
  logic [TAG_W-1:0]   btb_tag_q [N];
  logic [31:0]        btb_tgt_q [N];
  logic [1:0]         pht_q     [N];

  logic               pred_valid_q, pred_taken_q;
  logic [31:0]        pred_pc_q, pred_addr_q;
  logic               pred_taken_d;
  logic [31:0]        pred_addr_d;
  logic               hit;

  logic [INDEX_W-1:0] f_idx, u_idx, f_pidx, u_pidx;
  logic [TAG_W-1:0]   f_tag, u_tag;

  assign f_idx = fetch_pc[INDEX_W+1:2];
  assign f_tag = fetch_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign u_idx = pc_dispatch[INDEX_W+1:2];
  assign u_tag = pc_dispatch[INDEX_W+TAG_W+1:INDEX_W+2];

`ifdef BRANCH_GHR_EN
  logic [GHR_W-1:0] ghr_q;
  logic [INDEX_W-1:0] ghr_ext;
  assign ghr_ext = INDEX_W'(ghr_q);
  assign f_pidx  = f_idx ^ ghr_ext;
  assign u_pidx  = u_idx ^ ghr_ext;

  // History only advances on resolved branches, so a flush never needs to repair it.
  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else if (update_en) ghr_q <= {ghr_q[GHR_W-2:0], taken_or_not_actual};
  end
`else
  logic [GHR_W-1:0] unused_ghr;
  assign unused_ghr = '0;
  assign f_pidx = f_idx;
  assign u_pidx = u_idx;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], fetch_pc[31:INDEX_W+TAG_W+2],
                            pc_dispatch[1:0], pc_dispatch[31:INDEX_W+TAG_W+2]};

  // Reads see pre-update contents; a same-cycle update to the same entry is not bypassed.
  always_comb begin
    hit          = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    pred_taken_d = hit && pht_q[f_pidx][1];
    pred_addr_d  = pred_taken_d ? btb_tgt_q[f_idx] : fetch_pc + 32'd8;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_addr_q  <= '0;
    end else if (branch_flush) begin
      pred_valid_q <= 1'b0;
    end else if (!stall) begin
      pred_valid_q <= fetch_valid;
      if (fetch_valid) begin
        pred_pc_q    <= fetch_pc;
        pred_taken_q <= pred_taken_d;
        pred_addr_q  <= pred_addr_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '0;
      for (int i = 0; i < N; i++) pht_q[i] <= 2'b01;
    end else if (update_en) begin
      if (taken_or_not_actual) begin
        btb_valid_q[u_idx] <= 1'b1;
        if (pht_q[u_pidx] != 2'b11) pht_q[u_pidx] <= pht_q[u_pidx] + 2'b01;
      end else if (pht_q[u_pidx] != 2'b00) begin
        pht_q[u_pidx] <= pht_q[u_pidx] - 2'b01;
      end
    end
  end

  // Tag/target carry no reset: the valid bit gates their use.
  always_ff @(posedge clk) begin
    if (!rst && update_en && taken_or_not_actual) begin
      btb_tag_q[u_idx] <= u_tag;
      btb_tgt_q[u_idx] <= branch_actual_addr;
    end
  end

  assign pred_valid          = pred_valid_q;
  assign pred_pc             = pred_pc_q;
  assign pre_is_branch_taken = pred_taken_q;
  assign pre_branch_addr     = pred_addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default build): reset, training, saturation, alias, stall/flush, RAW ordering, wrap.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_valid, branch_flush;
  logic [31:0] fetch_pc;
  logic        pred_valid, pre_is_branch_taken;
  logic [31:0] pred_pc, pre_branch_addr;
  logic        update_en, taken_or_not_actual;
  logic [31:0] pc_dispatch, branch_actual_addr;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .fetch_valid         (fetch_valid),
    .fetch_pc            (fetch_pc),
    .branch_flush        (branch_flush),
    .pred_valid          (pred_valid),
    .pred_pc             (pred_pc),
    .pre_is_branch_taken (pre_is_branch_taken),
    .pre_branch_addr     (pre_branch_addr),
    .update_en           (update_en),
    .pc_dispatch         (pc_dispatch),
    .taken_or_not_actual (taken_or_not_actual),
    .branch_actual_addr  (branch_actual_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    update_en   = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    update_en           = 1'b1;
    pc_dispatch         = pc;
    taken_or_not_actual = tk;
    branch_actual_addr  = tgt;
  endtask

  initial begin
    // Reset with simultaneous fetch and taken update: reset must win.
    rst = 1'b1; stall = 1'b0; branch_flush = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h1C00_0000;
    upd(32'h1C00_0000, 1'b1, 32'h1C00_0100);
    step();
    chk("rst_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_taken", {31'd0, pre_is_branch_taken}, 32'd0);
    chk("rst_pc", pred_pc, 32'd0);
    chk("rst_addr", pre_branch_addr, 32'd0);
    rst = 1'b0;

    // Test 1: cold fetch predicts pc+8
    fetch(32'h1C00_0000); step();
    chk("t1_valid", {31'd0, pred_valid}, 32'd1);
    chk("t1_pc", pred_pc, 32'h1C00_0000);
    chk("t1_taken", {31'd0, pre_is_branch_taken}, 32'd0);
    chk("t1_addr", pre_branch_addr, 32'h1C00_0008);

    // Test 2: one taken update allocates and moves counter 01->10
    fetch_valid = 1'b0; upd(32'h1C00_0010, 1'b1, 32'h1C00_0100); step();
    chk("t2_idle_valid", {31'd0, pred_valid}, 32'd0);
    fetch(32'h1C00_0010); step();
    chk("t2_taken", {31'd0, pre_is_branch_taken}, 32'd1);
    chk("t2_addr", pre_branch_addr, 32'h1C00_0100);

    // Test 4: alias with different tag misses
    fetch(32'h1C00_0110); step();
    chk("t4_taken", {31'd0, pre_is_branch_taken}, 32'd0);
    chk("t4_addr", pre_branch_addr, 32'h1C00_0118);

    // Test 3: two not-taken -> 00, prediction not-taken
    fetch_valid = 1'b0; upd(32'h1C00_0010, 1'b0, 32'h1C00_0018); step(); step();
    fetch(32'h1C00_0010); step();
    chk("t3_taken", {31'd0, pre_is_branch_taken}, 32'd0);
    chk("t3_addr", pre_branch_addr, 32'h1C00_0018);
    // Third not-taken stays 00; one taken then gives 01 (still not taken)
    fetch_valid = 1'b0; upd(32'h1C00_0010, 1'b0, 32'h1C00_0018); step();
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0100); step();
    fetch(32'h1C00_0010); step();
    chk("t3_sat0_taken", {31'd0, pre_is_branch_taken}, 32'd0);
    chk("t3_sat0_addr", pre_branch_addr, 32'h1C00_0018);
    // Three taken -> 11 saturated, one not-taken -> 10 (taken, BTB target kept)
    fetch_valid = 1'b0; upd(32'h1C00_0010, 1'b1, 32'h1C00_0100); step(); step(); step();
    upd(32'h1C00_0010, 1'b0, 32'h1C00_0018); step();
    fetch(32'h1C00_0010); step();
    chk("t3_sat3_taken", {31'd0, pre_is_branch_taken}, 32'd1);
    chk("t3_sat3_addr", pre_branch_addr, 32'h1C00_0100);

    // Test 5: stall holds outputs while fetch_pc changes
    stall = 1'b1;
    fetch(32'h1C00_0000); step();
    chk("t5_s1_pc", pred_pc, 32'h1C00_0010);
    fetch(32'h1C00_0110); step();
    chk("t5_s2_addr", pre_branch_addr, 32'h1C00_0100);
    fetch(32'h1C00_0200); step();
    chk("t5_s3_pc", pred_pc, 32'h1C00_0010);
    chk("t5_s3_taken", {31'd0, pre_is_branch_taken}, 32'd1);
    chk("t5_s3_valid", {31'd0, pred_valid}, 32'd1);
    // Flush under stall, with a not-taken update (10->01) in the same cycle
    branch_flush = 1'b1; upd(32'h1C00_0010, 1'b0, 32'h1C00_0018); step();
    chk("t5_flush_valid", {31'd0, pred_valid}, 32'd0);
    branch_flush = 1'b0; stall = 1'b0;
    fetch(32'h1C00_0010); step();
    chk("t5_trained_taken", {31'd0, pre_is_branch_taken}, 32'd0);
    chk("t5_trained_addr", pre_branch_addr, 32'h1C00_0018);
    // Flush without stall drops a valid fetch
    branch_flush = 1'b1; fetch(32'h1C00_0000); step();
    chk("t5_flush2_valid", {31'd0, pred_valid}, 32'd0);
    branch_flush = 1'b0;

    // Test 6: same-cycle lookup/update reads old state (counter 01)
    fetch(32'h1C00_0010); upd(32'h1C00_0010, 1'b1, 32'h1C00_0200); step();
    chk("t6_old_taken", {31'd0, pre_is_branch_taken}, 32'd0);
    chk("t6_old_addr", pre_branch_addr, 32'h1C00_0018);
    fetch(32'h1C00_0010); step();
    chk("t6_new_taken", {31'd0, pre_is_branch_taken}, 32'd1);
    chk("t6_new_addr", pre_branch_addr, 32'h1C00_0200);

    // Address wrap on not-taken prediction
    fetch(32'hFFFF_FFF8); step();
    chk("wrap_addr", pre_branch_addr, 32'h0000_0000);
    chk("wrap_pc", pred_pc, 32'hFFFF_FFF8);

    fetch_valid = 1'b0; step();
    chk("idle_valid", {31'd0, pred_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
